// File: rtl/imul_pkg.sv
// Shared types and constants for the variable-latency iterative integer multiplier.
package imul_pkg;

  typedef enum logic [1:0] {
    IMUL_IDLE,
    IMUL_CALC,
    IMUL_DONE
  } imul_state_t;

  localparam logic IMUL_OP_UNSIGNED = 1'b0;
  localparam logic IMUL_OP_SIGNED   = 1'b1;

endpackage

// File: rtl/imul_int_mul_var_dpath.sv
// Datapath for the shift-add multiplier: operand magnitude capture, accumulate,
// shift, iteration counter and final sign restoration.
module vc_SimpleAdder #(
  parameter int W = 64
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);
  assign out = in0 + in1;
endmodule

module imul_int_mul_var_dpath
  import imul_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_calc,
  input  logic               i_sgn,
  input  logic [NBITS-1:0]   i_a,
  input  logic [NBITS-1:0]   i_b,
  output logic               o_bm_next_zero,
  output logic               o_cnt_last,
  output logic [2*NBITS-1:0] o_result
);
  localparam int PW = 2 * NBITS;
  localparam int CW = $clog2(NBITS) + 1;

  logic [PW-1:0]    r_am;
  logic [NBITS-1:0] r_bm;
  logic [PW-1:0]    r_prod;
  logic             r_neg;
  logic [CW-1:0]    r_cnt;

  logic [NBITS-1:0] w_a_abs;
  logic [NBITS-1:0] w_b_abs;
  logic [PW-1:0]    w_sum;
  logic [PW-1:0]    w_prod_neg;

  // The most negative value maps to 2^(NBITS-1), which is still a valid unsigned magnitude.
  assign w_a_abs = (i_sgn && i_a[NBITS-1]) ? (~i_a + 1'b1) : i_a;
  assign w_b_abs = (i_sgn && i_b[NBITS-1]) ? (~i_b + 1'b1) : i_b;

  vc_SimpleAdder #(.W(PW)) u_add (
    .in0 (r_prod),
    .in1 (r_am),
    .out (w_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_am   <= '0;
      r_bm   <= '0;
      r_prod <= '0;
      r_neg  <= 1'b0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_am   <= {{NBITS{1'b0}}, w_a_abs};
      r_bm   <= w_b_abs;
      r_prod <= '0;
      r_neg  <= i_sgn & (i_a[NBITS-1] ^ i_b[NBITS-1]);
      r_cnt  <= '0;
    end else if (i_calc) begin
      if (r_bm[0]) r_prod <= w_sum;
      r_am  <= r_am << 1;
      r_bm  <= r_bm >> 1;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_bm_next_zero = (r_bm[NBITS-1:1] == '0);
  assign o_cnt_last     = (r_cnt == CW'(NBITS - 1));

  assign w_prod_neg = ~r_prod + 1'b1;
  assign o_result   = r_neg ? w_prod_neg : r_prod;

endmodule

// File: rtl/imul_int_mul_var.sv
// Variable-latency iterative integer multiplier with val/rdy request and response streams.
// State | meaning: IDLE accept request; CALC one shift-add per cycle; DONE hold product.
module imul_int_mul_var
  import imul_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2*NBITS:0]   istream_msg,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [2*NBITS-1:0] ostream_msg
);
  imul_state_t r_state;

  logic             w_sgn;
  logic [NBITS-1:0] w_a;
  logic [NBITS-1:0] w_b;
  logic             w_load;
  logic             w_calc;
  logic             w_bm_next_zero;
  logic             w_cnt_last;

  assign w_sgn = (istream_msg[2*NBITS] == IMUL_OP_SIGNED);
  assign w_a   = istream_msg[2*NBITS-1:NBITS];
  assign w_b   = istream_msg[NBITS-1:0];

  assign istream_rdy = (r_state == IMUL_IDLE);
  assign ostream_val = (r_state == IMUL_DONE);
  assign w_load      = istream_rdy & istream_val;
  assign w_calc      = (r_state == IMUL_CALC);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IMUL_IDLE;
    end else begin
      case (r_state)
        IMUL_IDLE: if (istream_val) r_state <= IMUL_CALC;
        IMUL_CALC: if (w_bm_next_zero || w_cnt_last) r_state <= IMUL_DONE;
        IMUL_DONE: if (ostream_rdy) r_state <= IMUL_IDLE;
        default:   r_state <= IMUL_IDLE;
      endcase
    end
  end

  imul_int_mul_var_dpath #(.NBITS(NBITS)) u_dpath (
    .clk            (clk),
    .reset          (reset),
    .i_load         (w_load),
    .i_calc         (w_calc),
    .i_sgn          (w_sgn),
    .i_a            (w_a),
    .i_b            (w_b),
    .o_bm_next_zero (w_bm_next_zero),
    .o_cnt_last     (w_cnt_last),
    .o_result       (ostream_msg)
  );

endmodule

// File: tb/tb_imul_int_mul_var.sv
// Randomised and directed checks of imul_int_mul_var at NBITS=32 and NBITS=8
// against an arithmetic reference model.
module tb_imul_int_mul_var;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ordy = 1'b0;

  logic        v32 = 1'b0, r32, ov32;
  logic [64:0] m32 = '0;
  logic [63:0] om32;

  logic        v8 = 1'b0, r8, ov8;
  logic [16:0] m8 = '0;
  logic [15:0] om8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imul_int_mul_var #(.NBITS(32)) dut32 (
    .clk(clk), .reset(reset),
    .istream_val(v32), .istream_rdy(r32), .istream_msg(m32),
    .ostream_val(ov32), .ostream_rdy(ordy), .ostream_msg(om32)
  );

  imul_int_mul_var #(.NBITS(8)) dut8 (
    .clk(clk), .reset(reset),
    .istream_val(v8), .istream_rdy(r8), .istream_msg(m8),
    .ostream_val(ov8), .ostream_rdy(ordy), .ostream_msg(om8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_irdy(input bit w8);
    return w8 ? r8 : r32;
  endfunction

  function automatic logic get_oval(input bit w8);
    return w8 ? ov8 : ov32;
  endfunction

  function automatic logic [63:0] get_omsg(input bit w8);
    return w8 ? {48'b0, om8} : om32;
  endfunction

  // Operand value as a mathematical integer, honouring the signed/unsigned request bit.
  function automatic longint opval(input bit w8, input bit sgn, input logic [31:0] x);
    if (w8) return sgn ? longint'($signed(x[7:0])) : longint'({56'b0, x[7:0]});
    return sgn ? longint'($signed(x)) : longint'({32'b0, x});
  endfunction

  function automatic logic [63:0] ref_prod(input bit w8, input bit sgn,
                                           input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] r;
    p = opval(w8, sgn, a) * opval(w8, sgn, b);
    r = p;
    return w8 ? (r & 64'hFFFF) : r;
  endfunction

  // Iterations = position of the highest set bit of |b| plus one, at least one.
  function automatic int ref_k(input bit w8, input bit sgn, input logic [31:0] b);
    longint m;
    int k;
    m = opval(w8, sgn, b);
    if (m < 0) m = -m;
    k = 1;
    for (int i = 0; i < 32; i++)
      if ((m >> i) % 2 == 1) k = i + 1;
    return k;
  endfunction

  task automatic drive(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      v8 = 1'b1;
      m8 = {sgn, a[7:0], b[7:0]};
    end else begin
      v32 = 1'b1;
      m32 = {sgn, a, b};
    end
  endtask

  task automatic undrive();
    v8  = 1'b0;
    v32 = 1'b0;
  endtask

  task automatic run_op(input bit w8, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input string tag);
    logic [63:0] held;
    int k;
    int guard;
    guard = 0;
    while (!get_irdy(w8) && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    check({tag, ":rdy"}, 64'(get_irdy(w8)), 64'd1);
    drive(w8, sgn, a, b);
    @(posedge clk); #1;
    undrive();
    k = 0;
    while (!get_oval(w8) && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check({tag, ":k"}, 64'(k), 64'(ref_k(w8, sgn, b)));
    check({tag, ":msg"}, get_omsg(w8), ref_prod(w8, sgn, a, b));
    held = get_omsg(w8);
    for (int i = 0; i < hold; i++) begin
      drive(w8, 1'b0, $urandom, $urandom);
      @(posedge clk); #1;
      check({tag, ":hold_msg"}, get_omsg(w8), held);
      check({tag, ":hold_rdy"}, 64'(get_irdy(w8)), 64'd0);
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check({tag, ":post_oval"}, 64'(get_oval(w8)), 64'd0);
    check({tag, ":post_rdy"}, 64'(get_irdy(w8)), 64'd1);
    undrive();
  endtask

  task automatic directed(input bit w8);
    logic [31:0] mneg;
    logic [31:0] ones;
    mneg = w8 ? 32'h80 : 32'h8000_0000;
    ones = w8 ? 32'hFF : 32'hFFFF_FFFF;
    run_op(w8, 1'b0, 32'd3, 32'd4, 0, "u3x4");
    run_op(w8, 1'b1, 32'hFFFF_FFFB, 32'd3, 0, "s-5x3");
    run_op(w8, 1'b0, 32'hDEAD_BEEF, 32'd0, 0, "bzero");
    run_op(w8, 1'b0, ones, ones, 0, "umax");
    run_op(w8, 1'b1, mneg, mneg, 0, "sminxmin");
    run_op(w8, 1'b1, mneg, 32'd1, 0, "sminx1");
    run_op(w8, 1'b0, 32'd9, 32'd5, 5, "bp");
    run_op(w8, 1'b1, 32'd7, 32'hFFFF_FFFE, 0, "after_bp");
  endtask

  initial begin
    bit w8, sgn;
    logic [31:0] a, b;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy32", 64'(r32), 64'd1);
    check("rst_oval32", 64'(ov32), 64'd0);
    check("rst_msg32", om32, 64'd0);
    check("rst_rdy8", 64'(r8), 64'd1);
    check("rst_oval8", 64'(ov8), 64'd0);
    check("rst_msg8", {48'b0, om8}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    directed(1'b0);
    directed(1'b1);

    drive(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    undrive();
    repeat (9) @(posedge clk);
    #1;
    check("mid_calc_oval", 64'(ov32), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_rdy", 64'(r32), 64'd1);
    check("midrst_oval", 64'(ov32), 64'd0);
    check("midrst_msg", om32, 64'd0);
    run_op(1'b0, 1'b0, 32'd7, 32'd6, 0, "7x6");
    check("7x6_is_42", om32, 64'd42);

    for (int i = 0; i < 120; i++) begin
      w8  = (i % 2) == 1;
      sgn = $urandom_range(0, 1) == 1;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      run_op(w8, sgn, a, b, $urandom_range(0, 2), w8 ? "rnd8" : "rnd32");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
